// File: rtl/traj_pkg.sv
// Shared widths, Q-format types and the launch trig table for trajectory_bank.
package traj_pkg;

    localparam int TRAJ_N_SLOTS = 4;
    localparam int TRAJ_XW      = 11;
    localparam int TRAJ_YW      = 11;
    localparam int TRAJ_FRAC    = 8;
    localparam int TRAJ_PW      = TRAJ_XW + TRAJ_FRAC + 1;
    localparam int TRAJ_VW      = TRAJ_FRAC + 4;

    typedef logic signed [TRAJ_PW-1:0] pos_t;
    typedef logic signed [TRAJ_VW-1:0] vel_t;

    typedef struct packed {
        int vx;
        int vy;
    } trig_t;

    // sin(j*pi/32) in Q16 for the first quadrant, j = 0..16
    function automatic int sin_q16(input int j);
        case (j)
            0:       return 0;
            1:       return 6424;
            2:       return 12785;
            3:       return 19024;
            4:       return 25080;
            5:       return 30893;
            6:       return 36410;
            7:       return 41576;
            8:       return 46341;
            9:       return 50660;
            10:      return 54491;
            11:      return 57798;
            12:      return 60547;
            13:      return 62714;
            14:      return 64277;
            15:      return 65220;
            default: return 65536;
        endcase
    endfunction

    // Launch velocity for angle index k (k*180/32 degrees) at speed v0,
    // rounded to nearest; indices above 16 aim left (negative vx).
    function automatic trig_t trig_entry(input int k, input int v0);
        trig_t e;
        int    cq;
        int    sq;
        logic  cneg;
        if (k <= 16) begin
            cq   = sin_q16(16 - k);
            sq   = sin_q16(k);
            cneg = 1'b0;
        end else begin
            cq   = sin_q16(k - 16);
            sq   = sin_q16(32 - k);
            cneg = 1'b1;
        end
        e.vx = (v0 * cq + 32768) / 65536;
        if (cneg) e.vx = -e.vx;
        e.vy = (v0 * sq + 32768) / 65536;
        return e;
    endfunction

endpackage

// File: rtl/trig_lut.sv
// Combinational launch-angle table: theta index -> (vx, vy) in Q-format.
module trig_lut
    import traj_pkg::*;
#(
    parameter int VW = TRAJ_VW,
    parameter int V0 = 1024
) (
    input  logic        [4:0]    theta,
    output logic signed [VW-1:0] vx,
    output logic signed [VW-1:0] vy
);

    logic signed [VW-1:0] vx_tab [32];
    logic signed [VW-1:0] vy_tab [32];

    for (genvar k = 0; k < 32; k++) begin : g_tab
        localparam trig_t E = trig_entry(k, V0);
        assign vx_tab[k] = VW'(E.vx);
        assign vy_tab[k] = VW'(E.vy);
    end

    assign vx = vx_tab[theta];
    assign vy = vy_tab[theta];

endmodule

// File: rtl/trajectory_bank.sv
// Multi-slot projectile integrator: launch allocator, per-tick update sweep
// over all slots, automatic retirement when a fruit leaves the playfield.
module trajectory_bank
    import traj_pkg::*;
#(
    parameter int N_SLOTS = TRAJ_N_SLOTS,
    parameter int XW      = TRAJ_XW,
    parameter int YW      = TRAJ_YW,
    parameter int FRAC    = TRAJ_FRAC,
    parameter int V0      = 1024,
    parameter int GRAV    = 8,
    parameter int XBASE   = 144,
    parameter int XSTEP   = 16,
    parameter int X_MAX   = 800,
    localparam int SW     = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic                    sysck,
    input  logic                    reset_n,
    input  logic                    on,
    input  logic                    coordck,
    input  logic                    launch_valid,
    output logic                    launch_ready,
    input  logic [4:0]              xin,
    input  logic [4:0]              theta,
    output logic [SW-1:0]           launch_slot,
    output logic [N_SLOTS*XW-1:0]   x_coord,
    output logic [N_SLOTS*YW-1:0]   y_coord,
    output logic [N_SLOTS-1:0]      act,
    output logic [N_SLOTS-1:0]      retire,
    output logic                    busy,
    output logic                    overrun
);

    localparam int PW = XW + FRAC + 1;
    localparam int VW = FRAC + 4;
    localparam int VMIN = -(1 << (VW - 1));
    localparam logic signed [PW-1:0] XMAX_P = PW'(X_MAX);
    localparam logic signed [VW-1:0] VMIN_V = VW'(VMIN);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t               state;
    logic [SW-1:0]        idx;
    logic                 ck_prev;
    logic signed [PW-1:0] px [N_SLOTS];
    logic signed [PW-1:0] py [N_SLOTS];
    logic signed [VW-1:0] vx [N_SLOTS];
    logic signed [VW-1:0] vy [N_SLOTS];

    logic signed [VW-1:0] lut_vx, lut_vy;
    logic [SW-1:0]        free_idx;
    logic                 launch_go, tick_edge, upd_en, hit;
    logic signed [PW-1:0] x0, cur_x, cur_y, nx, ny, nx_int;
    logic signed [VW-1:0] cur_vx, cur_vy, nvy;
    int                   vy_sub;

    trig_lut #(.VW(VW), .V0(V0)) u_lut (
        .theta (theta),
        .vx    (lut_vx),
        .vy    (lut_vy)
    );

    assign launch_ready = on & ~(&act);
    assign launch_go    = launch_valid & launch_ready;
    assign tick_edge    = coordck & ~ck_prev;
    assign upd_en       = (state == SWEEP) && act[idx];
    assign x0           = PW'(XBASE + int'(xin) * XSTEP) <<< FRAC;

    // Lowest-index free slot; scanned downward so the last hit wins
    always_comb begin
        free_idx = '0;
        for (int unsigned j = 0; j < N_SLOTS; j++) begin
            if (!act[N_SLOTS-1-j]) free_idx = SW'(N_SLOTS - 1 - j);
        end
    end

    // Next state of the slot under the sweep index and its retire test
    always_comb begin
        cur_x  = px[idx];
        cur_y  = py[idx];
        cur_vx = vx[idx];
        cur_vy = vy[idx];
        nx     = cur_x + {{(PW-VW){cur_vx[VW-1]}}, cur_vx};
        ny     = cur_y + {{(PW-VW){cur_vy[VW-1]}}, cur_vy};
        vy_sub = int'(cur_vy) - GRAV;
        nvy    = (vy_sub < VMIN) ? VMIN_V : VW'(vy_sub);
        nx_int = nx >>> FRAC;
        hit    = nx_int[PW-1] || (nx_int > XMAX_P) || (ny[PW-1] && nvy[VW-1]);
    end

    // Sweep FSM, tick edge history and sticky overrun flag
    always_ff @(posedge sysck or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            ck_prev <= 1'b0;
        end else if (!on) begin
            state   <= IDLE;
            idx     <= '0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            ck_prev <= 1'b0;
        end else begin
            ck_prev <= coordck;
            if (tick_edge && busy) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (tick_edge) begin
                        state <= SWEEP;
                        busy  <= 1'b1;
                        idx   <= '0;
                    end
                end
                SWEEP: begin
                    if (idx == SW'(N_SLOTS - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Slot register file: launch load, sweep update and retirement.
    // A launch only targets a free slot and the sweep only writes an active
    // one, so both may act in the same cycle without colliding.
    always_ff @(posedge sysck or negedge reset_n) begin
        if (!reset_n) begin
            act         <= '0;
            retire      <= '0;
            launch_slot <= '0;
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                px[i] <= '0; py[i] <= '0; vx[i] <= '0; vy[i] <= '0;
            end
        end else if (!on) begin
            act         <= '0;
            retire      <= '0;
            launch_slot <= '0;
            for (int unsigned i = 0; i < N_SLOTS; i++) begin
                px[i] <= '0; py[i] <= '0; vx[i] <= '0; vy[i] <= '0;
            end
        end else begin
            retire <= '0;
            if (upd_en) begin
                if (hit) begin
                    px[idx]     <= '0;
                    py[idx]     <= '0;
                    vx[idx]     <= '0;
                    vy[idx]     <= '0;
                    act[idx]    <= 1'b0;
                    retire[idx] <= 1'b1;
                end else begin
                    px[idx] <= nx;
                    py[idx] <= ny;
                    vy[idx] <= nvy;
                end
            end
            if (launch_go) begin
                px[free_idx]  <= x0;
                py[free_idx]  <= '0;
                vx[free_idx]  <= lut_vx;
                vy[free_idx]  <= lut_vy;
                act[free_idx] <= 1'b1;
                launch_slot   <= free_idx;
            end
        end
    end

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_out
        assign x_coord[g*XW +: XW] = px[g][FRAC +: XW];
        assign y_coord[g*YW +: YW] = py[g][FRAC +: YW];
    end

endmodule

// File: tb/tb_trajectory_bank.sv
// Directed self-checking bench for trajectory_bank (default build plus a
// zero-gravity build sharing clock, enable, tick and launch data).
module tb_trajectory_bank;

    localparam int NS = 4;
    localparam int XW = 11;
    localparam int YW = 11;

    logic              sysck = 1'b0;
    logic              reset_n, on, coordck, lv_a, lv_b;
    logic [4:0]        xin, theta;
    logic              lr_a, lr_b, busy_a, busy_b, ovr_a, ovr_b;
    logic [1:0]        ls_a, ls_b;
    logic [NS*XW-1:0]  xc_a, xc_b;
    logic [NS*YW-1:0]  yc_a, yc_b;
    logic [NS-1:0]     act_a, act_b, ret_a, ret_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [NS-1:0] hist_a [7];
    logic          bhist  [7];
    logic [NS-1:0] racc_a, racc_b;

    trajectory_bank dut_a (
        .sysck(sysck), .reset_n(reset_n), .on(on), .coordck(coordck),
        .launch_valid(lv_a), .launch_ready(lr_a), .xin(xin), .theta(theta),
        .launch_slot(ls_a), .x_coord(xc_a), .y_coord(yc_a), .act(act_a),
        .retire(ret_a), .busy(busy_a), .overrun(ovr_a)
    );

    trajectory_bank #(.GRAV(0)) dut_b (
        .sysck(sysck), .reset_n(reset_n), .on(on), .coordck(coordck),
        .launch_valid(lv_b), .launch_ready(lr_b), .xin(xin), .theta(theta),
        .launch_slot(ls_b), .x_coord(xc_b), .y_coord(yc_b), .act(act_b),
        .retire(ret_b), .busy(busy_b), .overrun(ovr_b)
    );

    always #5 sysck = ~sysck;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    function automatic int xa(input int s);
        return int'($signed(xc_a[s*XW +: XW]));
    endfunction
    function automatic int ya(input int s);
        return int'($signed(yc_a[s*YW +: YW]));
    endfunction
    function automatic int xb(input int s);
        return int'($signed(xc_b[s*XW +: XW]));
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sysck);
        #1;
    endtask

    task automatic launch(input logic which, input logic [4:0] x, input logic [4:0] t);
        xin   = x;
        theta = t;
        if (which) lv_b = 1'b1;
        else       lv_a = 1'b1;
        step();
        lv_a = 1'b0;
        lv_b = 1'b0;
    endtask

    // One frame tick; records retire/busy after each cycle of the sweep
    task automatic do_tick();
        racc_a  = '0;
        racc_b  = '0;
        coordck = 1'b1;
        step();
        hist_a[0] = ret_a;
        bhist[0]  = busy_a;
        coordck   = 1'b0;
        for (int i = 1; i < 7; i++) begin
            step();
            hist_a[i] = ret_a;
            bhist[i]  = busy_a;
            racc_a    = racc_a | ret_a;
            racc_b    = racc_b | ret_b;
        end
    endtask

    initial begin
        reset_n = 1'b1; on = 1'b0; coordck = 1'b0;
        lv_a = 1'b0; lv_b = 1'b0; xin = '0; theta = '0;
        #2 reset_n = 1'b0;
        step(); step();
        check("rst_act",    act_a, 0);
        check("rst_coords", {31'd0, |{xc_a, yc_a}}, 0);
        check("rst_busy",   busy_a, 0);
        check("rst_ovr",    ovr_a, 0);
        check("rst_ready",  lr_a, 0);
        reset_n = 1'b1;
        step();
        check("off_ready", lr_a, 0);
        on = 1'b1;
        #1;
        check("on_ready", lr_a, 1);

        // Vertical launch from column 0: ballistic arc, retire on tick 258
        launch(1'b0, 5'd0, 5'd16);
        check("t1_slot", ls_a, 0);
        check("t1_act",  act_a, 4'b0001);
        check("t1_x0",   xa(0), 144);
        check("t1_y0",   ya(0), 0);
        for (int n = 1; n <= 258; n++) begin
            do_tick();
            if (n == 1) begin
                check("t1_y_tick1", ya(0), 4);
                check("t1_busy_first", bhist[0], 1);
                check("t1_busy_last",  bhist[3], 1);
                check("t1_busy_fall",  bhist[4], 0);
            end
            if (n == 2)   check("t1_y_tick2", ya(0), 7);
            if (n == 128) begin
                check("t1_y_peak", ya(0), 258);
                check("t1_x_hold", xa(0), 144);
            end
            if (n == 257) begin
                check("t1_y_257",   ya(0), 0);
                check("t1_act_257", act_a, 4'b0001);
                check("t1_noret_257", racc_a, 0);
            end
            if (n == 258) begin
                check("t1_retire_pulse", hist_a[1], 4'b0001);
                check("t1_retire_once",  hist_a[2], 0);
                check("t1_act_258",      act_a, 0);
                check("t1_x_zero",       xa(0), 0);
            end
        end

        // Horizontal launch: falls below y=0 on the second tick
        launch(1'b0, 5'd0, 5'd0);
        check("t2_slot", ls_a, 0);
        do_tick();
        check("t2_x_tick1", xa(0), 148);
        check("t2_y_tick1", ya(0), 0);
        check("t2_act_tick1", act_a, 4'b0001);
        do_tick();
        check("t2_retire", hist_a[1], 4'b0001);
        check("t2_act",    act_a, 0);
        check("t2_x_zero", xa(0), 0);

        // Fill all four slots back to back, retire slot 1, reuse it
        xin = 5'd0; theta = 5'd16; lv_a = 1'b1;
        step(); check("t4_slot0", ls_a, 0);
        theta = 5'd0;
        step(); check("t4_slot1", ls_a, 1);
        theta = 5'd16;
        step(); check("t4_slot2", ls_a, 2);
        step(); check("t4_slot3", ls_a, 3);
        lv_a = 1'b0;
        check("t4_act_full", act_a, 4'b1111);
        check("t4_not_ready", lr_a, 0);
        do_tick();
        check("t4_x1_tick1", xa(1), 148);
        check("t4_act_tick1", act_a, 4'b1111);
        do_tick();
        check("t4_retire1", hist_a[2], 4'b0010);
        check("t4_act_tick2", act_a, 4'b1101);
        check("t4_ready_again", lr_a, 1);
        launch(1'b0, 5'd0, 5'd16);
        check("t4_reuse_slot", ls_a, 1);
        check("t4_act_refill", act_a, 4'b1111);

        // Zero gravity, rightmost column: exits right edge on tick 41
        launch(1'b1, 5'd31, 5'd0);
        check("t3_slot", ls_b, 0);
        check("t3_x0",   xb(0), 640);
        for (int n = 1; n <= 41; n++) begin
            do_tick();
            if (n == 1)  check("t3_x_tick1", xb(0), 644);
            if (n == 40) begin
                check("t3_x_tick40", xb(0), 800);
                check("t3_act_40",   act_b, 4'b0001);
            end
            if (n == 41) begin
                check("t3_retire41", racc_b, 4'b0001);
                check("t3_act_41",   act_b, 0);
                check("t3_x_zero",   xb(0), 0);
            end
        end

        // Second tick edge two cycles into a sweep is dropped
        launch(1'b1, 5'd0, 5'd0);
        check("t5_x0", xb(0), 144);
        check("t5_ovr_before", ovr_b, 0);
        coordck = 1'b1; step();
        coordck = 1'b0; step();
        coordck = 1'b1; step();
        coordck = 1'b0;
        repeat (6) step();
        check("t5_ovr_set",   ovr_b, 1);
        check("t5_one_step",  xb(0), 148);
        check("t5_busy_done", busy_b, 0);

        // Game disable clears slots and sticky flag on the next cycle
        check("t6_act_before", act_a, 4'b1111);
        check("t6_ovr_before", ovr_a, 1);
        on = 1'b0;
        step();
        check("t6_off_act",    act_a, 0);
        check("t6_off_coords", {31'd0, |{xc_a, yc_a}}, 0);
        check("t6_off_ready",  lr_a, 0);
        check("t6_off_ovr",    ovr_a, 0);
        on = 1'b1;
        step();

        // Asynchronous reset in the middle of a sweep
        launch(1'b0, 5'd2, 5'd16);
        check("t6_x_col2", xa(0), 176);
        coordck = 1'b1; step();
        coordck = 1'b0; step(); step();
        check("t6_mid_busy", busy_a, 1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_act",    act_a, 0);
        check("t6_rst_busy",   busy_a, 0);
        check("t6_rst_coords", {31'd0, |{xc_a, yc_a, xc_b, yc_b}}, 0);
        check("t6_rst_ovr_b",  ovr_b, 0);
        reset_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
